// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_if.sv
// Instruction-memory bus: req/gnt request phase, in-order rvalid response phase.
interface fetch_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata
  );

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with push/pop/flush and an occupancy count; head is the oldest entry.
module fetch_fifo #(
  parameter type T = logic [31:0],
  parameter int unsigned DEPTH = 4,
  localparam int unsigned CW = $clog2(DEPTH + 1),
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  T              push_data,
  input  logic          pop,
  input  logic          flush,
  output T              head,
  output logic [CW-1:0] count
);

  T              mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
    if (p == AW'(DEPTH - 1)) return '0;
    return p + AW'(1);
  endfunction

  // Accept a pop only when occupied; a push into a full FIFO is allowed if a pop frees a slot.
  always_comb begin
    do_pop  = pop && (count != '0);
    do_push = push && ((count != CW'(DEPTH)) || do_pop);
    head    = mem[rd_ptr];
  end

  // Storage array, no reset needed.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers and occupancy; flush empties the FIFO in one cycle.
  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= bump(wr_ptr);
      if (do_pop)  rd_ptr <= bump(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: fetch PC, in-order imem requests, response buffer, stall and redirect.
// Optional performance counters are built when FETCH_PERF_EN is defined.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned BUF_DEPTH       = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  fetch_if.master     imem,
  output logic [31:0] INST_F,
  output logic [31:0] PC_F,
  output logic [31:0] PC4_F,
  output logic        valid_F
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_killed
`endif
);

  localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned BW = $clog2(BUF_DEPTH + 1);
  localparam int unsigned SW = ((OW > BW) ? OW : BW) + 1;

  logic [31:0]  pc_q;
  logic [OW-1:0] outstanding;
  logic [OW-1:0] drop_cnt;
  logic [31:0]  tag_head;
  logic [OW-1:0] tag_count;
  fetch_entry_t buf_in;
  fetch_entry_t buf_head;
  logic [BW-1:0] buf_count;
  logic         buf_valid;
  logic         pop;
  logic         grant;
  logic         keep;
  logic         discard;
  logic [SW-1:0] occupancy;

  fetch_fifo #(.T(logic [31:0]), .DEPTH(MAX_OUTSTANDING)) u_tag (
    .clk(clk), .rst(rst),
    .push(grant), .push_data(pc_q),
    .pop(imem.imem_rvalid), .flush(1'b0),
    .head(tag_head), .count(tag_count)
  );

  fetch_fifo #(.T(fetch_entry_t), .DEPTH(BUF_DEPTH)) u_buf (
    .clk(clk), .rst(rst),
    .push(keep), .push_data(buf_in),
    .pop(pop), .flush(redirect),
    .head(buf_head), .count(buf_count)
  );

  // Issue, response routing and IF/ID outputs; redirect masks everything in its own cycle.
  always_comb begin
    buf_valid = rst && (buf_count != '0) && !redirect;
    pop       = buf_valid && !stall;
    // Live requests (not marked for drop) will each need a buffer slot when they return.
    occupancy = SW'(outstanding) - SW'(drop_cnt) + SW'(buf_count) - SW'(pop);
    imem.imem_req  = rst && !redirect &&
                     (outstanding < OW'(MAX_OUTSTANDING)) &&
                     (occupancy < SW'(BUF_DEPTH));
    imem.imem_addr = pc_q;
    grant   = imem.imem_req && imem.imem_gnt;
    discard = imem.imem_rvalid && (redirect || (drop_cnt != '0));
    keep    = imem.imem_rvalid && !discard;
    buf_in  = '{pc: tag_head, inst: imem.imem_rdata};
    valid_F = buf_valid;
    INST_F  = buf_valid ? buf_head.inst : NOP_INST;
    PC_F    = buf_valid ? buf_head.pc : '0;
    PC4_F   = buf_valid ? buf_head.pc + 32'd4 : '0;
  end

  // Fetch PC, in-flight count and number of in-flight responses still to be discarded.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q        <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      outstanding <= outstanding + OW'(grant) - OW'(imem.imem_rvalid);
      if (redirect) begin
        pc_q     <= redirect_pc & 32'hFFFF_FFFC;
        // Everything still in flight after this cycle belongs to the old path.
        drop_cnt <= outstanding - OW'(imem.imem_rvalid);
      end else begin
        if (grant) pc_q <= pc_q + 32'd4;
        if (imem.imem_rvalid && (drop_cnt != '0)) drop_cnt <= drop_cnt - OW'(1);
      end
    end
  end

`ifdef FETCH_PERF_EN
  // Count instructions handed to IF/ID and responses thrown away by redirects.
  always_ff @(posedge clk) begin
    if (!rst) begin
      perf_fetched <= '0;
      perf_killed  <= '0;
    end else begin
      if (pop)     perf_fetched <= perf_fetched + 32'd1;
      if (discard) perf_killed  <= perf_killed + 32'd1;
    end
  end
`endif

  a_no_stray_rvalid : assert property (
    @(posedge clk) disable iff (!rst)
      imem.imem_rvalid |-> ((outstanding != '0) && (tag_count != '0))
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios followed by randomized traffic,
// all cycles compared against a queue-based reference model.
module tb_fetch_stage;
  import fetch_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam int MAXO  = 2;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [31:0] inst_f, pc_f, pc4_f;
  logic        valid_f;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched, perf_killed;
`endif

  fetch_if bus ();

  fetch_stage #(.RESET_PC(RST_PC), .MAX_OUTSTANDING(MAXO), .BUF_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem(bus), .INST_F(inst_f), .PC_F(pc_f), .PC4_F(pc4_f), .valid_F(valid_f)
`ifdef FETCH_PERF_EN
    , .perf_fetched(perf_fetched), .perf_killed(perf_killed)
`endif
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; bit kill; } flight_t;
  typedef struct { logic [31:0] addr; int unsigned due; } pend_t;

  flight_t      m_fl[$];
  fetch_entry_t m_buf[$];
  pend_t        pend[$];
  logic [31:0]  m_pc;
  int unsigned  m_fetched, m_killed;
  int unsigned  cyc, lat_extra;
  int           gnt_mode;
  logic [31:0]  key;
  int           checks, errors;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return a ^ key;
  endfunction

  task automatic monitor();
    bit          e_valid, pop_e, e_req;
    logic [31:0] e_pc, e_inst;
    int          live;
    flight_t     f;
    if (!rst) begin
      m_fl.delete(); m_buf.delete(); pend.delete();
      m_pc = RST_PC; m_fetched = 0; m_killed = 0;
      check("rst_valid", valid_f, 0);
      check("rst_inst", inst_f, NOP_INST);
      check("rst_pc", pc_f, 0);
      check("rst_pc4", pc4_f, 0);
      check("rst_req", bus.imem_req, 0);
      return;
    end
`ifdef FETCH_PERF_EN
    check("perf_fetched", perf_fetched, m_fetched);
    check("perf_killed", perf_killed, m_killed);
`endif
    e_valid = !redirect && (m_buf.size() > 0);
    e_inst  = e_valid ? m_buf[0].inst : NOP_INST;
    e_pc    = e_valid ? m_buf[0].pc : '0;
    pop_e   = e_valid && !stall;
    live = 0;
    foreach (m_fl[i]) if (!m_fl[i].kill) live++;
    e_req = !redirect && (m_fl.size() < MAXO) && ((live + m_buf.size() - int'(pop_e)) < DEPTH);
    check("valid_F", valid_f, e_valid);
    check("INST_F", inst_f, e_inst);
    check("PC_F", pc_f, e_pc);
    check("PC4_F", pc4_f, e_valid ? e_pc + 32'd4 : 32'd0);
    check("imem_req", bus.imem_req, e_req);
    if (e_req) check("imem_addr", bus.imem_addr, m_pc);
    // memory side: remember every actual grant
    if (bus.imem_req && bus.imem_gnt) pend.push_back('{addr: bus.imem_addr, due: cyc + 1 + lat_extra});
    // model update for the coming edge
    if (pop_e) begin void'(m_buf.pop_front()); m_fetched++; end
    if (bus.imem_rvalid) begin
      check("rsp_has_request", m_fl.size() != 0, 1);
      if (m_fl.size() != 0) begin
        f = m_fl.pop_front();
        if (f.kill || redirect) m_killed++;
        else m_buf.push_back('{pc: f.addr, inst: data_of(f.addr)});
      end
    end
    if (e_req && bus.imem_gnt) begin
      m_fl.push_back('{addr: m_pc, kill: 1'b0});
      m_pc = m_pc + 32'd4;
    end
    if (redirect) begin
      foreach (m_fl[i]) m_fl[i].kill = 1'b1;
      m_buf.delete();
      m_pc = redirect_pc & 32'hFFFF_FFFC;
    end
  endtask

  task automatic mem_update();
    cyc++;
    if (rst && pend.size() > 0 && pend[0].due <= cyc) begin
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = data_of(pend[0].addr);
      void'(pend.pop_front());
    end else begin
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata  = 32'hDEAD_BEEF;
    end
    case (gnt_mode)
      0:       bus.imem_gnt = 1'b1;
      1:       bus.imem_gnt = 1'b0;
      default: bus.imem_gnt = ($urandom_range(0, 99) < 70);
    endcase
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    mem_update();
  endtask

  initial begin
    logic [31:0] frozen_pc, base_killed;
    int          n;
    checks = 0; errors = 0; cyc = 0; lat_extra = 0; gnt_mode = 0; key = '0;
    bus.imem_gnt = 1'b1; bus.imem_rvalid = 1'b0; bus.imem_rdata = '0;

    // 1: reset for two cycles, then first request at RESET_PC
    tick(); tick();
    rst = 1'b1;
    #1;
    check("t1_req", bus.imem_req, 1);
    check("t1_addr", bus.imem_addr, RST_PC);

    // 2: zero-wait memory, first grant this cycle, output two cycles later
    tick(); tick();
    for (int k = 0; k < 3; k++) begin
      check("t2_valid", valid_f, 1);
      check("t2_pc", pc_f, RST_PC + 32'(4 * k));
      check("t2_inst", inst_f, RST_PC + 32'(4 * k));
      check("t2_pc4", pc4_f, RST_PC + 32'(4 * k + 4));
      tick();
    end

    // 3: stall five cycles, buffer fills and requests stop, then drains in order
    frozen_pc = (m_buf.size() > 0) ? m_buf[0].pc : 32'hFFFF_FFFF;
    stall = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      check("t3_frozen_pc", pc_f, frozen_pc);
      check("t3_frozen_inst", inst_f, frozen_pc);
      if (k == 4) check("t3_req_off", bus.imem_req, 0);
      tick();
    end
    stall = 1'b0;
    for (int k = 0; k < 6; k++) begin
      #1;
      check("t3_drain_pc", pc_f, frozen_pc + 32'(4 * k));
      tick();
    end

    // 4: two requests in flight, redirect to a misaligned target
    base_killed = m_killed;
    lat_extra = 6;
    tick(); tick(); tick();
    redirect = 1'b1; redirect_pc = 32'h0000_2003;
    tick();
    redirect = 1'b0; lat_extra = 0;
    n = 0;
    while (!valid_f && n < 40) begin tick(); n++; end
    #1;
    check("t4_valid", valid_f, 1);
    check("t4_pc", pc_f, 32'h0000_2000);
    check("t4_inst", inst_f, 32'h0000_2000);
`ifdef FETCH_PERF_EN
    check("t4_perf_killed", perf_killed, base_killed + 32'd2);
`endif

    // 5: redirect together with stall, then grant withheld for three cycles
    gnt_mode = 1; bus.imem_gnt = 1'b0;
    stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_3000;
    #1;
    check("t5_valid", valid_f, 0);
    check("t5_inst", inst_f, NOP_INST);
    check("t5_req", bus.imem_req, 0);
    tick();
    stall = 1'b0; redirect = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("t5_hold_req", bus.imem_req, 1);
      check("t5_hold_addr", bus.imem_addr, 32'h0000_3000);
      tick();
    end
    gnt_mode = 0; bus.imem_gnt = 1'b1;
    n = 0;
    while (!valid_f && n < 40) begin tick(); n++; end
    #1;
    check("t5_first_pc", pc_f, 32'h0000_3000);

    // randomized traffic after a fresh reset
    rst = 1'b0; key = $urandom;
    tick(); tick();
    rst = 1'b1; gnt_mode = 2;
    for (int k = 0; k < 800; k++) begin
      stall       = ($urandom_range(0, 99) < 30);
      redirect    = ($urandom_range(0, 99) < 5);
      redirect_pc = $urandom;
      lat_extra   = $urandom_range(0, 2);
      tick();
    end
    stall = 1'b0; redirect = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
